// File: rtl/audio_sampler_fifo.sv
// Multi-channel audio sampler: buffers packed sample frames in a small FIFO,
// pops one frame per sample period and drives one first-order sigma-delta
// PWM bitstream per channel.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-low reset
//   enable          1 = tick counter runs; 0 = counter and current codes frozen
//   in_valid        input frame valid
//   in_data         packed frame, channel k in [k*CODE_WIDTH +: CODE_WIDTH]
//   in_ready        FIFO can accept a frame this cycle
//   pwm_out         per-channel sigma-delta bitstream
//   sample_tick     one-cycle pulse on each sample boundary
//   fifo_level      frames currently buffered
//   underflow_count saturating count of ticks that found the FIFO empty
//   clear_underflow synchronous clear of underflow_count (wins over increment)
module audio_sampler_fifo #(
    parameter int unsigned CODE_WIDTH     = 10,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned SAMPLE_PERIOD  = 2500,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned UNDERFLOW_HOLD = 1,
    parameter int unsigned MUTE_CODE      = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 in_valid,
    input  logic [NUM_CH*CODE_WIDTH-1:0]         in_data,
    output logic                                 in_ready,
    output logic [NUM_CH-1:0]                    pwm_out,
    output logic                                 sample_tick,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic [15:0]                          underflow_count,
    input  logic                                 clear_underflow
);

    localparam int unsigned FrameW = NUM_CH * CODE_WIDTH;
    localparam int unsigned CntW   = $clog2(SAMPLE_PERIOD);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [CntW-1:0]       CntLast   = CntW'(SAMPLE_PERIOD - 1);
    localparam logic [LvlW-1:0]       LvlFull   = LvlW'(FIFO_DEPTH);
    localparam logic [CODE_WIDTH-1:0] MuteCh    = CODE_WIDTH'(MUTE_CODE);
    localparam logic [FrameW-1:0]     MuteFrame = {NUM_CH{MuteCh}};

    logic [CntW-1:0]       cnt_q;
    logic [FrameW-1:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [LvlW-1:0]       level_q;
    logic [FrameW-1:0]     codes_q;
    logic [15:0]           underflow_q;
    logic [CODE_WIDTH:0]   acc_q [NUM_CH];

    logic tick;
    logic fifo_empty;
    logic push;
    logic pop;

    always_comb begin
        tick       = enable && (cnt_q == CntLast);
        fifo_empty = (level_q == '0);
        // Ready looks only at registered level: a full FIFO stays not-ready
        // even when a pop happens in the same cycle.
        in_ready   = (level_q != LvlFull);
        push       = in_valid && in_ready;
        pop        = tick && !fifo_empty;
    end

    assign sample_tick     = tick;
    assign fifo_level      = level_q;
    assign underflow_count = underflow_q;

    always_comb begin
        pwm_out = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            pwm_out[k] = acc_q[k][CODE_WIDTH];
        end
    end

    // Sample period counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        end
    end

    // Frame FIFO; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            level_q <= level_q + LvlW'(push) - LvlW'(pop);
        end
    end

    // Current codes: new frame on a tick, hold or mute when the FIFO is empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            codes_q <= MuteFrame;
        end else if (tick) begin
            if (!fifo_empty) begin
                codes_q <= mem_q[rd_ptr_q];
            end else if (UNDERFLOW_HOLD == 0) begin
                codes_q <= MuteFrame;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow_q <= '0;
        end else if (clear_underflow) begin
            underflow_q <= '0;
        end else if (tick && fifo_empty && (underflow_q != 16'hFFFF)) begin
            underflow_q <= underflow_q + 16'd1;
        end
    end

    // First-order sigma-delta: the carry out of the accumulator is the bitstream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= {1'b0, acc_q[k][CODE_WIDTH-1:0]}
                          + {1'b0, codes_q[k*CODE_WIDTH +: CODE_WIDTH]};
            end
        end
    end

endmodule

// File: tb/tb_audio_sampler_fifo.sv
module tb_audio_sampler_fifo;

    localparam int CW  = 10;
    localparam int NCH = 2;
    localparam int P   = 8;
    localparam int D   = 4;
    localparam int FW  = NCH * CW;
    localparam int LW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          in_valid;
    logic [FW-1:0] in_data;
    logic          clear_underflow;

    logic           rdy_h, rdy_m;
    logic [NCH-1:0] pwm_h, pwm_m;
    logic           tick_h, tick_m;
    logic [LW-1:0]  lvl_h, lvl_m;
    logic [15:0]    uc_h, uc_m;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    audio_sampler_fifo #(
        .CODE_WIDTH(CW), .NUM_CH(NCH), .SAMPLE_PERIOD(P), .FIFO_DEPTH(D),
        .UNDERFLOW_HOLD(1), .MUTE_CODE(0)
    ) dut_h (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_h), .pwm_out(pwm_h), .sample_tick(tick_h), .fifo_level(lvl_h),
        .underflow_count(uc_h), .clear_underflow(clear_underflow)
    );

    audio_sampler_fifo #(
        .CODE_WIDTH(CW), .NUM_CH(NCH), .SAMPLE_PERIOD(P), .FIFO_DEPTH(D),
        .UNDERFLOW_HOLD(0), .MUTE_CODE(0)
    ) dut_m (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_m), .pwm_out(pwm_m), .sample_tick(tick_m), .fifo_level(lvl_m),
        .underflow_count(uc_m), .clear_underflow(clear_underflow)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: frame queue, per-mode current codes, underflow counter
    int            m_cnt;
    logic [FW-1:0] m_q[$];
    int            m_hold[NCH];
    int            m_mute[NCH];
    int            m_uc;
    bit            m_zero_h[NCH];
    bit            m_zero_m[NCH];
    bit            m_tk, m_empty, m_push;
    logic [FW-1:0] m_f;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0;
            m_q.delete();
            m_uc = 0;
            for (int k = 0; k < NCH; k++) begin
                m_hold[k] = 0; m_mute[k] = 0; m_zero_h[k] = 1'b1; m_zero_m[k] = 1'b1;
            end
        end else begin
            // Codes in force before this edge are what the DAC adds at this edge
            for (int k = 0; k < NCH; k++) begin
                m_zero_h[k] = (m_hold[k] == 0);
                m_zero_m[k] = (m_mute[k] == 0);
            end
            m_tk    = enable && (m_cnt == P - 1);
            m_empty = (m_q.size() == 0);
            m_push  = in_valid && (m_q.size() < D);
            if (m_tk) begin
                if (!m_empty) begin
                    m_f = m_q.pop_front();
                    for (int k = 0; k < NCH; k++) begin
                        m_hold[k] = int'(m_f[k*CW +: CW]);
                        m_mute[k] = int'(m_f[k*CW +: CW]);
                    end
                end else begin
                    if (m_uc < 65535) m_uc++;
                    for (int k = 0; k < NCH; k++) m_mute[k] = 0;
                end
            end
            if (clear_underflow) m_uc = 0;
            if (m_push) m_q.push_back(in_data);
            if (enable) m_cnt = (m_cnt + 1) % P;
        end
    end

    always @(negedge clk) begin
        if (mon_on && rst === 1'b1) begin
            check("tick_h", 32'(tick_h), 32'(enable && m_cnt == P - 1));
            check("tick_m", 32'(tick_m), 32'(enable && m_cnt == P - 1));
            check("level_h", 32'(lvl_h), m_q.size());
            check("level_m", 32'(lvl_m), m_q.size());
            check("ready_h", 32'(rdy_h), 32'(m_q.size() != D));
            check("ready_m", 32'(rdy_m), 32'(m_q.size() != D));
            check("ucount_h", 32'(uc_h), m_uc);
            check("ucount_m", 32'(uc_m), m_uc);
            for (int k = 0; k < NCH; k++) begin
                if (m_zero_h[k]) check("pwm_zero_h", 32'(pwm_h[k]), 0);
                if (m_zero_m[k]) check("pwm_zero_m", 32'(pwm_m[k]), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_tick();
        int n = 0;
        enable = 1'b1;
        do begin
            step();
            n++;
        end while (m_cnt != 0 && n < 2 * P);
        check("tick_reached", m_cnt, 0);
        enable = 1'b0;
    endtask

    // Over w*1024 consecutive cycles a constant code c yields exactly c*w highs
    task automatic duty_check(input string tag, input int w, input int h0, input int h1,
                              input int u0, input int u1);
        int c[4];
        c = '{0, 0, 0, 0};
        step();
        repeat (w * 1024) begin
            @(negedge clk);
            c[0] += int'(pwm_h[0]); c[1] += int'(pwm_h[1]);
            c[2] += int'(pwm_m[0]); c[3] += int'(pwm_m[1]);
        end
        check({tag, "_h_ch0"}, c[0], h0 * w);
        check({tag, "_h_ch1"}, c[1], h1 * w);
        check({tag, "_m_ch0"}, c[2], u0 * w);
        check({tag, "_m_ch1"}, c[3], u1 * w);
    endtask

    task automatic push_one(input int c0, input int c1);
        in_valid = 1'b1;
        in_data  = {CW'(c1), CW'(c0)};
        step();
        in_valid = 1'b0;
    endtask

    int fr0[6] = '{40, 300, 777, 1023, 5, 600};
    int fr1[6] = '{960, 12, 512, 1, 99, 444};
    int idx;
    int uc0;
    bit acc;

    initial begin
        rst = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; clear_underflow = 1'b0;
        #12;
        rst = 1'b1;
        mon_on = 1'b1;

        // Idle: three empty ticks
        enable = 1'b1;
        repeat (3 * P) step();
        check("idle_uc3", 32'(uc_h), 3);
        check("idle_pwm", 32'(pwm_h), 0);
        check("idle_ready", 32'(rdy_h), 1);

        // Fill and backpressure with enable low
        enable = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        repeat (8) begin
            in_data = {CW'(fr1[idx]), CW'(fr0[idx])};
            acc = (m_q.size() < D);
            step();
            if (acc && idx < 5) idx++;
        end
        in_valid = 1'b0;
        check("fill_level", 32'(lvl_h), 4);
        check("fill_ready", 32'(rdy_h), 0);
        for (int i = 0; i < 4; i++) begin
            run_to_tick();
            duty_check("play", 1, fr0[i], fr1[i], fr0[i], fr1[i]);
        end

        // Duty
        push_one(256, 768);
        run_to_tick();
        duty_check("duty", 4, 256, 768, 256, 768);

        // Underflow modes
        push_one(512, 512);
        run_to_tick();
        uc0 = m_uc;
        run_to_tick();
        run_to_tick();
        check("uflow_count", 32'(uc_h), uc0 + 2);
        duty_check("uflow", 1, 512, 512, 0, 0);

        // Push on a tick cycle with the FIFO empty: underflow, frame waits a tick
        enable = 1'b1;
        while (m_cnt != P - 1) step();
        uc0 = m_uc;
        push_one(100, 900);
        check("tickpush_uc", 32'(uc_h), uc0 + 1);
        check("tickpush_level", 32'(lvl_h), 1);
        run_to_tick();
        duty_check("tickpush", 1, 100, 900, 100, 900);

        // Clear wins over an incrementing tick
        enable = 1'b1;
        while (m_cnt != P - 1) step();
        clear_underflow = 1'b1;
        step();
        clear_underflow = 1'b0;
        check("clear_wins", 32'(uc_h), 0);

        // Saturation from a preloaded count
        enable = 1'b0;
        dut_h.underflow_q <= 16'hFFFE;
        dut_m.underflow_q <= 16'hFFFE;
        m_uc = 65534;
        repeat (3) run_to_tick();
        check("sat_h", 32'(uc_h), 65535);
        check("sat_m", 32'(uc_m), 65535);

        // Asynchronous reset between edges with frames buffered
        enable = 1'b1;
        for (int i = 0; i < 3; i++) push_one(i * 200 + 50, 1000 - i * 100);
        enable = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_level", 32'(lvl_h), 0);
        check("arst_pwm_h", 32'(pwm_h), 0);
        check("arst_pwm_m", 32'(pwm_m), 0);
        check("arst_uc", 32'(uc_h), 0);
        check("arst_tick", 32'(tick_h), 0);
        rst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable          = ($urandom_range(0, 9) != 0);
            in_valid        = (i < 1500) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 15) == 0);
            in_data         = FW'($urandom);
            clear_underflow = ($urandom_range(0, 63) == 0);
            step();
        end
        in_valid = 1'b0;
        clear_underflow = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_sampler_fifo.md
Name: audio_sampler_fifo

Overview:
Multi-channel, parametrised successor to the single-channel audio sampler. It accepts packed sample frames from the synth over a valid/ready handshake and buffers them in a small FIFO. It pops one frame per sample period and drives one first-order sigma-delta PWM output per channel. Underflow handling is selectable (hold last frame or mute), and a saturating underflow counter is exposed for debug. It sits between the synth/scaler and the board audio pins.

Parameters:
CODE_WIDTH, 10, bits per channel sample code (unsigned)
NUM_CH, 2, number of audio channels; frame width = NUM_CH*CODE_WIDTH
SAMPLE_PERIOD, 2500, clk cycles per sample tick (>=2)
FIFO_DEPTH, 4, frame entries; power of two, >=2
UNDERFLOW_HOLD, 1, 1 = repeat last frame on underflow; 0 = output MUTE_CODE
MUTE_CODE, 0, per-channel code used at reset and on underflow when UNDERFLOW_HOLD=0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  1 = sampling runs; 0 = tick counter and current codes frozen, FIFO still accepts frames
in_valid  in  1  frame valid
in_data  in  NUM_CH*CODE_WIDTH  frame; channel k in bits [k*CODE_WIDTH +: CODE_WIDTH]
in_ready  out  1  frame accepted on cycles where in_valid && in_ready
pwm_out  out  NUM_CH  sigma-delta bitstream per channel
sample_tick  out  1  one-cycle pulse on each sample boundary
fifo_level  out  $clog2(FIFO_DEPTH+1)  frames currently buffered
underflow_count  out  16  saturating count of ticks that found the FIFO empty
clear_underflow  in  1  synchronous clear of underflow_count

Behaviour:
- Reset (rst=0, async): tick counter=0, FIFO empty, fifo_level=0, current codes=MUTE_CODE, DAC accumulators=0, pwm_out=0, sample_tick=0, underflow_count=0. in_ready=1 on the first edge after release.
- Tick counter: counts 0..SAMPLE_PERIOD-1 and wraps to 0 while enable=1; holds its value while enable=0.
- sample_tick=1 exactly in the cycle where counter==SAMPLE_PERIOD-1 and enable=1. Period is exactly SAMPLE_PERIOD cycles.
- On a tick edge:
  - FIFO non-empty: pop the head frame into the current codes register (visible to the DACs the next cycle).
  - FIFO empty: underflow_count += 1, saturating at 16'hFFFF. Current codes keep their value if UNDERFLOW_HOLD=1, else load MUTE_CODE on all channels.
- Push: in_ready = (fifo_level != FIFO_DEPTH), driven from registered state only, with no same-cycle dependence on the pop. A full FIFO with a simultaneous pop still shows in_ready=0.
- Push and pop in the same cycle: both occur, level unchanged.
- Push into an empty FIFO on a tick cycle: counts as an underflow. There is no bypass, and the frame is played on the next tick.
- in_data is ignored when in_valid=0. Pointers wrap modulo FIFO_DEPTH.
- clear_underflow: underflow_count=0 next edge. Clear wins over a simultaneous increment.
- DAC, per channel k: acc_k is CODE_WIDTH+1 bits; acc_k <= {1'b0, acc_k[CODE_WIDTH-1:0]} + code_k every cycle, including while enable=0; pwm_out[k] = acc_k[CODE_WIDTH] (registered).
  - Long-run duty = code_k / 2^CODE_WIDTH.
  - code 0 gives a constant 0; code all-ones gives 0 once per 2^CODE_WIDTH cycles.
- Reset asserted mid-operation immediately clears all state, including frames buffered in the FIFO. No partial frame survives.

Test Plan:
- Reset/idle (SAMPLE_PERIOD=8, NUM_CH=2, CODE_WIDTH=10): release rst, no input for 3 ticks -> pwm_out=2'b00 throughout, sample_tick pulses every 8 cycles, underflow_count=3, in_ready=1.
- Fill and backpressure (FIFO_DEPTH=4): hold in_valid=1 with frames F0..F5, enable=0 -> exactly F0..F3 accepted, in_ready=0 after the 4th accept, fifo_level=4. Set enable=1 -> frames play in order F0,F1,F2,F3, one per tick, and in_ready rises the cycle after the first pop.
- Duty check: single frame ch0=10'd256, ch1=10'd768, run 4096 cycles after pop -> high counts ch0=1024, ch1=3072 (±1).
- Underflow modes: play frame {512,512}, then FIFO empty for 2 ticks. UNDERFLOW_HOLD=1 -> codes stay 512, underflow_count=2. UNDERFLOW_HOLD=0, MUTE_CODE=0 -> codes become 0 after the first empty tick.
- Simultaneous events: push on a tick cycle with the FIFO empty -> underflow counted, frame played at the next tick. clear_underflow on an incrementing tick -> count=0. Saturation: preload 65534 via 3 underflows -> count stays 65535.
- Async reset mid-stream: assert rst=0 for 1 ns between edges with 3 frames buffered -> fifo_level=0, pwm_out=0, counter=0 immediately, with no clk edge required.
